bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_MASTERS, 3, number of requesting masters (2..4).
  MAX_BURST, 4, maximum consecutive locked grants to one master.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single system clock; all state updates on posedge.
  reset  in  1  synchronous, active-low reset.
  vsync  in  1  vertical-blank flag from the lcd block.
  req  in  NUM_MASTERS  per-master access request.
  lock  in  NUM_MASTERS  per-master "another access follows" flag.
  m_addr  in  16*NUM_MASTERS  packed master addresses; master i uses bits [16i+15:16i].
  m_wdata  in  8*NUM_MASTERS  packed master write data.
  m_rw  in  NUM_MASTERS  per-master direction; 1 = write.
  gnt  out  NUM_MASTERS  one-hot grant, high during that master's bus cycle.
  ack  out  NUM_MASTERS  one-cycle completion pulse.
  rdata  out  8  read data from the last completed read.
  bus_addr  out  16  shared peripheral address to the address decoder.
  bus_do  out  8  shared write data.
  bus_rw  out  1  shared direction; 1 = write.
  bus_di  in  8  read data muxed back by the address decoder.

Function
REQ-003 The FSM SHALL have two states: IDLE (no owner) and XFER (one bus cycle owned by a winner).
REQ-004 In IDLE with any req high, the next edge SHALL select a winner, register bus_addr, bus_do and bus_rw from it, set its gnt bit, and enter XFER.
REQ-005 bus_addr, bus_do, bus_rw and gnt SHALL be registered outputs, stable for the whole XFER cycle.
REQ-006 The edge ending XFER SHALL capture rdata from bus_di when bus_rw=0 (rdata holds otherwise), pulse ack of the winner for exactly one cycle, and clear bus_rw.
REQ-007 Latency SHALL be: req sampled at edge 0, bus driven in cycle 1, ack high in cycle 2; back-to-back grants SHALL occur with no idle cycle.
REQ-008 A granted request SHALL be consumed: at the edge ending XFER, the winner's req is ignored unless its lock is high.
REQ-009 If the winner's lock is high and fewer than MAX_BURST consecutive grants have gone to it, the same master SHALL be re-granted directly from XFER; the MAX_BURST-th grant SHALL force round-robin re-arbitration.
REQ-010 Arbitration SHALL be round-robin: search starts at last winner + 1, modulo NUM_MASTERS.
REQ-011 With no eligible request at the edge ending XFER, the next state SHALL be IDLE: gnt=0, bus_rw=0, bus_addr and bus_do hold.
REQ-012 bus_rw SHALL never be 1 outside XFER; at most one gnt bit SHALL be high.
REQ-013 Simultaneous req and reset low: reset SHALL win and no grant is issued.

Reset
REQ-014 With reset low at a posedge, the next state SHALL be: state=IDLE, gnt=0, ack=0, bus_rw=0, bus_addr=16'h0000, bus_do=0, rdata=0, burst counter=0, round-robin pointer=NUM_MASTERS-1 (master 0 searched first).
REQ-015 Reset mid-XFER SHALL abandon the transfer; no ack is issued for it.

Configuration
REQ-016 With ARB_VSYNC_PRIORITY_EN defined, while vsync=1 master 0 SHALL win any arbitration in which it requests, except when a locked burst is still continuing under REQ-009. The round-robin pointer SHALL still update.
REQ-017 Without ARB_VSYNC_PRIORITY_EN, vsync SHALL be ignored and arbitration SHALL be pure round-robin.

Structure
REQ-018 Package bus_pkg SHALL hold ADDR_W=16, DATA_W=8 and the state typedef {IDLE, XFER}.
REQ-019 Sub-module rr_picker SHALL hold the combinational round-robin one-hot selector (req vector and pointer in, one-hot plus index out).

Verification
REQ-020 The bench SHALL cover the following scenarios.
  Single write: master 1 writes addr 16'hF005, data 8'h41 -> bus_rw=1 in cycle 1 only, ack[1] in cycle 2.
  Single read: master 0 reads 16'h0000 with bus_di=8'h5A -> rdata=8'h5A and ack[0] in cycle 2.
  Contention: all three req high after reset -> grant order 0,1,2,0, no idle cycles.
  Lock: master 2 holds lock and req with MAX_BURST=4 while master 0 requests -> 4 grants to master 2, then master 0.
  vsync priority (macro defined): vsync=1, masters 0 and 1 request with pointer at 0 -> master 0 wins; without the macro -> master 1 wins.
  Reset mid-XFER: reset low during a write -> next cycle bus_rw=0, gnt=0, no ack.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths and state encoding for the bus arbiter
//
// Contents:
//   ADDR_W   peripheral address width
//   DATA_W   peripheral data width
//   state_t  arbiter FSM state {IDLE, XFER}
//   idx_w()  index width needed to name one of n masters

package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin one-hot selector
//
// Ports:
//   req     in   N      candidate request vector
//   ptr     in   IDX_W  last winner; search starts at ptr+1 modulo N
//   onehot  out  N      one-hot winner (zero when nothing requests)
//   idx     out  IDX_W  winner index (zero when nothing requests)
//   valid   out  1      some request was found

module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // The outer loop walks priority order (ptr+1 first, ptr itself last);
  // the inner loop keeps every bit select at a constant index.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid && req[i] && (i == ((int'(ptr) + k) % N))) begin
          valid     = 1'b1;
          onehot[i] = 1'b1;
          idx       = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with locked bursts
//
// Optional feature macro: ARB_VSYNC_PRIORITY_EN (master 0 wins while vsync=1).
//
// Ports:
//   clk       in   1              system clock, posedge
//   reset     in   1              synchronous, active-low
//   vsync     in   1              vertical-blank flag (priority hint)
//   req       in   NUM_MASTERS    per-master request
//   lock      in   NUM_MASTERS    per-master "another access follows"
//   m_addr    in   16*NUM_MASTERS packed master addresses
//   m_wdata   in   8*NUM_MASTERS  packed master write data
//   m_rw      in   NUM_MASTERS    per-master direction, 1 = write
//   gnt       out  NUM_MASTERS    one-hot grant during the owned bus cycle
//   ack       out  NUM_MASTERS    one-cycle completion pulse
//   rdata     out  8              data of the last completed read
//   bus_addr  out  16             shared peripheral address
//   bus_do    out  8              shared write data
//   bus_rw    out  1              shared direction, 1 = write
//   bus_di    in   8              read data from the address decoder

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_BURST   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vsync,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        lock,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        ack,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_do,
  output logic                          bus_rw,
  input  logic [DATA_W-1:0]             bus_di
);

  localparam int IDX_W = idx_w(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] PTR_RST     = IDX_W'(NUM_MASTERS - 1);

  // Registered state. ptr_q is the last winner; while in XFER it is also the
  // current owner, so no separate owner register is kept.
  state_t                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic [ADDR_W-1:0]        bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]        bus_do_q, bus_do_d;
  logic                     bus_rw_q, bus_rw_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;

  // Arbitration results.
  logic [NUM_MASTERS-1:0]   elig;
  logic                     own_req;
  logic                     own_lock;
  logic                     cont;
  logic                     vs_win;
  logic [NUM_MASTERS-1:0]   rr_onehot;
  logic [IDX_W-1:0]         rr_idx;
  logic                     rr_valid;
  logic                     win_valid;
  logic [IDX_W-1:0]         win_idx;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic                     sel_rw;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      bus_addr_q <= '0;
      bus_do_q   <= '0;
      bus_rw_q   <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= PTR_RST;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      bus_addr_q <= bus_addr_d;
      bus_do_q   <= bus_do_d;
      bus_rw_q   <= bus_rw_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state: eligibility, burst continuation and winner selection
  // ---------------------------------------------------------------------
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    elig     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i == int'(ptr_q)) begin
        own_req  = req[i];
        own_lock = lock[i];
      end
      // The owner's request has just been served; it only counts again
      // when the owner flags that another access follows.
      elig[i] = req[i] &&
                !((state_q == XFER) && (i == int'(ptr_q)) && !lock[i]);
    end
  end

  // A locked burst continues until MAX_BURST grants, then it must compete.
  assign cont = (state_q == XFER) && own_req && own_lock && (cnt_q < MAX_BURST_C);

`ifdef ARB_VSYNC_PRIORITY_EN
  assign vs_win = vsync && elig[0] && !cont;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign vs_win       = 1'b0;
`endif

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req    (elig),
    .ptr    (ptr_q),
    .onehot (rr_onehot),
    .idx    (rr_idx),
    .valid  (rr_valid)
  );

  always_comb begin
    win_valid = cont || vs_win || rr_valid;
    if (cont) begin
      win_idx = ptr_q;
    end else if (vs_win) begin
      win_idx = '0;
    end else begin
      win_idx = rr_idx;
    end
    state_d = win_valid ? XFER : IDLE;
  end

  // ---------------------------------------------------------------------
  // Outputs / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    gnt_d     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i == int'(win_idx)) begin
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_rw    = m_rw[i];
      end
      gnt_d[i] = win_valid && (i == int'(win_idx)) && rr_onehot_ok(i);
    end

    // gnt_q is non-zero exactly during XFER, so it doubles as the ack mask.
    ack_d = gnt_q;

    rdata_d = ((state_q == XFER) && !bus_rw_q) ? bus_di : rdata_q;

    bus_addr_d = win_valid ? sel_addr  : bus_addr_q;
    bus_do_d   = win_valid ? sel_wdata : bus_do_q;
    bus_rw_d   = win_valid && sel_rw;

    if (cont) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (win_valid) begin
      cnt_d = CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    ptr_d = win_valid ? win_idx : ptr_q;
  end

  // The picker's one-hot is only authoritative for round-robin wins; burst
  // continuation and vsync priority override it, so any index is accepted.
  function automatic logic rr_onehot_ok(input int i);
    return (cont || vs_win) ? 1'b1 : rr_onehot[i];
  endfunction

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign bus_addr = bus_addr_q;
  assign bus_do   = bus_do_q;
  assign bus_rw   = bus_rw_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter

module tb_bus_arbiter;

  localparam int NM = 3;
  localparam int MB = 4;
  localparam int AW = 16 * NM;
  localparam int DW = 8 * NM;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic [NM-1:0] req;
  logic [NM-1:0] lock;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [NM-1:0] m_rw;
  logic [NM-1:0] gnt;
  logic [NM-1:0] ack;
  logic [7:0]    rdata;
  logic [15:0]   bus_addr;
  logic [7:0]    bus_do;
  logic          bus_rw;
  logic [7:0]    bus_di;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 = nobody), last winner, grants in this burst.
  int            m_owner = -1;
  int            m_last  = NM - 1;
  int            m_cnt   = 0;
  logic [NM-1:0] exp_gnt = '0;
  logic [NM-1:0] exp_ack = '0;
  logic          exp_rw  = 1'b0;
  logic [15:0]   exp_addr = '0;
  logic [7:0]    exp_do   = '0;
  logic [7:0]    exp_rdata = '0;

  logic [NM-1:0] order [4];

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .MAX_BURST   (MB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .req      (req),
    .lock     (lock),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rw     (m_rw),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .bus_addr (bus_addr),
    .bus_do   (bus_do),
    .bus_rw   (bus_rw),
    .bus_di   (bus_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock edge of the arbitration rules, applied to the sampled inputs.
  task automatic model_edge();
    int win;
    logic [NM-1:0] elig;
    if (!reset) begin
      m_owner = -1; m_last = NM - 1; m_cnt = 0;
      exp_gnt = '0; exp_ack = '0; exp_rw = 1'b0;
      exp_addr = '0; exp_do = '0; exp_rdata = '0;
    end else begin
      win = -1;
      exp_ack = '0;
      if (m_owner >= 0) begin
        exp_ack[m_owner] = 1'b1;
        if (!exp_rw) exp_rdata = bus_di;
      end
      if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_cnt < MB) begin
        win = m_owner;
        m_cnt = m_cnt + 1;
      end else begin
        for (int i = 0; i < NM; i++)
          elig[i] = req[i] && !(i == m_owner && !lock[i]);
`ifdef ARB_VSYNC_PRIORITY_EN
        if (vsync && elig[0]) win = 0;
`endif
        for (int k = 1; k <= NM; k++)
          if (win < 0 && elig[(m_last + k) % NM]) win = (m_last + k) % NM;
        if (win >= 0) m_cnt = 1;
      end
      exp_gnt = '0;
      if (win >= 0) begin
        m_owner = win;
        m_last  = win;
        exp_gnt[win] = 1'b1;
        exp_addr = m_addr[16*win +: 16];
        exp_do   = m_wdata[8*win +: 8];
        exp_rw   = m_rw[win];
      end else begin
        m_owner = -1;
        exp_rw  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt",      32'(gnt),      32'(exp_gnt));
    chk("ack",      32'(ack),      32'(exp_ack));
    chk("bus_rw",   32'(bus_rw),   32'(exp_rw));
    chk("bus_addr", 32'(bus_addr), 32'(exp_addr));
    chk("bus_do",   32'(bus_do),   32'(exp_do));
    chk("rdata",    32'(rdata),    32'(exp_rdata));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("rw_only_in_xfer", 32'(bus_rw && (gnt == '0)), 32'd0);
  endtask

  initial begin
    reset = 1'b0; vsync = 1'b0; req = '0; lock = '0;
    m_addr = '0; m_wdata = '0; m_rw = '0; bus_di = '0;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

    // Reset state
    step(); step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rw", 32'(bus_rw), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'h0000);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b1;

    // Single write by master 1
    req = 3'b010; m_rw = 3'b010; m_addr[31:16] = 16'hF005; m_wdata[15:8] = 8'h41;
    step();
    chk("wr_gnt_c1", 32'(gnt), 32'b010);
    chk("wr_rw_c1", 32'(bus_rw), 32'd1);
    chk("wr_addr", 32'(bus_addr), 32'hF005);
    chk("wr_do", 32'(bus_do), 32'h41);
    chk("wr_ack_c1", 32'(ack), 32'd0);
    req = '0;
    step();
    chk("wr_ack_c2", 32'(ack), 32'b010);
    chk("wr_rw_c2", 32'(bus_rw), 32'd0);
    chk("wr_gnt_c2", 32'(gnt), 32'd0);
    step();
    chk("wr_ack_once", 32'(ack), 32'd0);

    // Single read by master 0
    m_rw = '0; m_addr[15:0] = 16'h0000; req = 3'b001;
    step();
    chk("rd_gnt_c1", 32'(gnt), 32'b001);
    chk("rd_rw_c1", 32'(bus_rw), 32'd0);
    req = '0; bus_di = 8'h5A;
    step();
    chk("rd_ack_c2", 32'(ack), 32'b001);
    chk("rd_rdata", 32'(rdata), 32'h5A);
    bus_di = 8'h00;
    step();
    chk("rd_rdata_hold", 32'(rdata), 32'h5A);

    // vsync with pointer at master 0, masters 0 and 1 requesting
    vsync = 1'b1; req = 3'b011; m_addr[15:0] = 16'h1000; m_addr[31:16] = 16'h1001;
    step();
`ifdef ARB_VSYNC_PRIORITY_EN
    chk("vsync_winner", 32'(gnt), 32'b001);
`else
    chk("vsync_winner", 32'(gnt), 32'b010);
`endif
    vsync = 1'b0; req = '0;
    step(); step();

    // Contention straight after reset
    reset = 1'b0; step(); reset = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_gnt", 32'(gnt), 32'(order[i]));
      if (i > 0) chk("cont_ack", 32'(ack), 32'(order[i-1]));
    end
    req = '0;
    step();
    chk("cont_last_ack", 32'(ack), 32'b001);
    step();

    // Locked burst by master 2 while master 0 waits
    req = 3'b100; lock = 3'b100;
    step();
    chk("lock_gnt1", 32'(gnt), 32'b100);
    req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_gnt_burst", 32'(gnt), 32'b100);
    end
    step();
    chk("lock_then_m0", 32'(gnt), 32'b001);
    req = '0; lock = '0;
    step(); step();

    // Reset in the middle of a write
    req = 3'b010; m_rw = 3'b010;
    step();
    chk("rx_gnt", 32'(gnt), 32'b010);
    chk("rx_rw", 32'(bus_rw), 32'd1);
    reset = 1'b0; req = '0;
    step();
    chk("rx_gnt_cleared", 32'(gnt), 32'd0);
    chk("rx_rw_cleared", 32'(bus_rw), 32'd0);
    chk("rx_no_ack", 32'(ack), 32'd0);
    reset = 1'b1;
    step();
    chk("rx_no_late_ack", 32'(ack), 32'd0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 63) != 0);
      vsync   = $urandom_range(0, 1) == 1;
      req     = NM'($urandom);
      lock    = NM'($urandom) & NM'($urandom);
      m_addr  = AW'({$urandom, $urandom});
      m_wdata = DW'($urandom);
      m_rw    = NM'($urandom);
      bus_di  = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
